key_debouncer: RTL and testbench

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/key_pkg.sv | 18 +
 rtl/key_sync.sv | 22 ++
 rtl/key_debouncer.sv | 134 +++++++++++++
 tb/tb_key_debouncer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key debouncer.
// Optional build macro: KEY_DEBOUNCER_REPEAT_EN (auto-repeat while held).
package key_pkg;

  localparam int CNT_W = 26;

  localparam int DEF_STABLE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY  = 25_000_000;
  localparam int DEF_REPEAT_PERIOD = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw active-low key; resets to the
// released level so a reset never looks like a press.
module key_sync (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_n_sync
);

  logic key_n_meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_n_meta <= 1'b1;
      key_n_sync <= 1'b1;
    end else begin
      key_n_meta <= key_n;
      key_n_sync <= key_n_meta;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Key debouncer: synchronizer, four-state debounce FSM and press/release pulses.
// Build macro KEY_DEBOUNCER_REPEAT_EN adds auto-repeat press pulses while held.
//
// Handshake: none; press and release_pulse are single-cycle registered strobes,
// never high together. The release strobe is named release_pulse because
// "release" is a reserved word. state_dbg mirrors the FSM state.
module key_debouncer
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  output logic       key_level,
  output logic       press,
  output logic       release_pulse,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             key_n_sync;
  logic             pressed;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  key_sync u_key_sync (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .key_n_sync (key_n_sync)
  );

  assign pressed   = ~key_n_sync;
  assign state_dbg = state;

`ifdef KEY_DEBOUNCER_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // Low while waiting for the first repeat, high once periodic repeats run.
  logic rep_phase;
`else
  // Repeat timing is not built; the parameters only keep the interface uniform.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      key_level     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
`ifdef KEY_DEBOUNCER_REPEAT_EN
      rep_phase     <= 1'b0;
`endif
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pressed) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        end

        ST_PRESS_WAIT: begin
          if (!pressed) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= ST_HELD;
            cnt       <= '0;
            key_level <= 1'b1;
            press     <= 1'b1;
`ifdef KEY_DEBOUNCER_REPEAT_EN
            rep_phase <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HELD: begin
          if (!pressed) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end
`ifdef KEY_DEBOUNCER_REPEAT_EN
          // The counter measures time since the last press pulse.
          else if (cnt == (rep_phase ? PERIOD_LAST : DELAY_LAST)) begin
            press     <= 1'b1;
            cnt       <= '0;
            rep_phase <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        ST_RELEASE_WAIT: begin
          if (pressed) begin
            // Release bounce: back to HELD silently, repeat timing restarts.
            state <= ST_HELD;
            cnt   <= '0;
`ifdef KEY_DEBOUNCER_REPEAT_EN
            rep_phase <= 1'b0;
`endif
          end else if (cnt == STABLE_LAST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            key_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          key_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed plus randomized bench for key_debouncer with a run-length reference
// model of the debounce rules.
module tb_key_debouncer;
  import key_pkg::*;

  localparam int S  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  // clock / reset
  logic       clock = 1'b0;
  logic       reset;
  logic       key_n;
  logic       key_level;
  logic       press;
  logic       release_pulse;
  logic [1:0] state_dbg;

  always #5 clock = ~clock;

  key_debouncer #(
    .STABLE_CYCLES (S),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_n         (key_n),
    .key_level     (key_level),
    .press         (press),
    .release_pulse (release_pulse),
    .state_dbg     (state_dbg)
  );

  // scoreboard state
  int n_assert = 0;
  int n_fail   = 0;

  logic h1, h2;          // last two key_n samples (h2 is what the FSM sees next)
  logic m_level;         // accepted level, 1 = pressed
  int   m_run;           // consecutive samples disagreeing with m_level
  int   m_held;          // edges spent in HELD since the last entry
  logic m_press, m_rel;

  int edge_no;
  int press_seen, rel_seen;
  int first_press_edge, first_rel_edge;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h1 = 1'b1; h2 = 1'b1;
    m_level = 1'b0; m_run = 0; m_held = 0;
    m_press = 1'b0; m_rel = 1'b0;
  endtask

  // A level is accepted once the synchronized key disagrees with the current
  // level for S+1 consecutive edges; any agreeing sample cancels the run.
  task automatic model_edge(input logic k);
    logic s;
    s = h2; h2 = h1; h1 = k;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if ((s == 1'b0) != m_level) begin
      m_run++;
      if (m_run == S + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        m_held  = 0;
        if (m_level) m_press = 1'b1;
        else         m_rel   = 1'b1;
      end
    end else begin
      if (m_level && m_run == 0) begin
        m_held++;
`ifdef KEY_DEBOUNCER_REPEAT_EN
        if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) m_press = 1'b1;
`endif
      end else begin
        m_held = 0;
      end
      m_run = 0;
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_level) return (m_run > 0) ? ST_RELEASE_WAIT : ST_HELD;
    else         return (m_run > 0) ? ST_PRESS_WAIT   : ST_IDLE;
  endfunction

  task automatic check_all();
    check_bit("key_level", key_level, m_level);
    check_bit("press", press, m_press);
    check_bit("release", release_pulse, m_rel);
    check_bit("press_and_release", press & release_pulse, 1'b0);
    check_vec("state", 8'(state_dbg), 8'(model_state()));
  endtask

  task automatic check_zero(input string tag);
    check_bit({tag, "_level"}, key_level, 1'b0);
    check_bit({tag, "_press"}, press, 1'b0);
    check_bit({tag, "_release"}, release_pulse, 1'b0);
    check_vec({tag, "_state"}, 8'(state_dbg), 8'(ST_IDLE));
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic tick(input logic k);
    key_n = k;
    @(posedge clock);
    model_edge(k);
    edge_no++;
    #1;
    check_all();
    if (press) begin
      press_seen++;
      got_q.push_back(8'(edge_no));
      if (first_press_edge < 0) first_press_edge = edge_no;
    end
    if (release_pulse) begin
      rel_seen++;
      if (first_rel_edge < 0) first_rel_edge = edge_no;
    end
    @(negedge clock);
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k);
  endtask

  task automatic start_window();
    edge_no = 0;
    press_seen = 0; rel_seen = 0;
    first_press_edge = -1; first_rel_edge = -1;
    got_q.delete();
    exp_q.delete();
  endtask

  // reset asserted between clock edges; outputs must clear without an edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_zero("rst_async");
    model_reset();
    @(posedge clock);
    #1 check_zero("rst_held");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    key_n = 1'b1;
    model_reset();
    start_window();
    repeat (2) @(negedge clock);
    check_zero("reset_state");
    reset = 1'b0;

    hold(1'b1, 5);

    // clean press: pulse after edge S+3 = 7
    start_window();
    hold(1'b0, 12);
    check_vec("press_edge", 8'(first_press_edge), 8'd7);
    check_vec("press_count", 8'(press_seen), 8'd1);
    check_bit("held_level", key_level, 1'b1);

    // clean release: pulse after edge 7
    start_window();
    hold(1'b1, 12);
    check_vec("release_edge", 8'(first_rel_edge), 8'd7);
    check_vec("release_count", 8'(rel_seen), 8'd1);
    check_bit("released_level", key_level, 1'b0);

    // press bounce of three cycles is rejected
    start_window();
    hold(1'b0, 3);
    hold(1'b1, 12);
    check_vec("bounce_press", 8'(press_seen), 8'd0);
    check_vec("bounce_release", 8'(rel_seen), 8'd0);

    // release bounce of two cycles while held
    hold(1'b0, 12);
    start_window();
    hold(1'b1, 2);
    hold(1'b0, 12);
    check_vec("rel_bounce_release", 8'(rel_seen), 8'd0);
    check_vec("rel_bounce_press", 8'(press_seen), 8'd0);
    check_bit("rel_bounce_level", key_level, 1'b1);

    // reset while held, key still down: fresh press after edge 7 (plus repeats)
    do_reset();
    start_window();
    hold(1'b0, 40);
    exp_q.push_back(8'd7);
`ifdef KEY_DEBOUNCER_REPEAT_EN
    for (int e = 7 + RD; e <= 40; e += RP) exp_q.push_back(8'(e));
`endif
    check_vec("post_reset_press_edge", 8'(first_press_edge), 8'd7);
    check_vec("press_pulse_count", 8'(got_q.size()), 8'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_vec("press_pulse_edge", got_q[i], exp_q[i]);
    hold(1'b1, 12);

    // randomized bouncing and holding, with occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      hold(1'($urandom_range(0, 1)), $urandom_range(1, (seg % 4 == 0) ? 30 : S + 4));
    end
    hold(1'b1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
